hdu_ctrl: RTL and testbench
===========================

// Module: hdu_ctrl
// PURPOSE
// Parametrised hazard detection/stall controller for the in-order core. Sits beside the
// pipeline regs; drives fetch/decode/PC stalls and decode/execute flushes. Adds load-use
// RAW detection, N-cycle multi-access stall counter, held self-instruct fetch stall, flush.
// PARAMETERS
// REG_AW   4  register address width
// NUM_SRC  2  decode source operands checked for RAW
// CNT_W    4  width of multi-access stall length/counter
// R0_ZERO  1  1: register 0 hardwired, never hazards
// PORTS
// clk_i           in   1              clock
// rst_i           in   1              synchronous active-high reset
// d_valid_i       in   1              decode stage holds valid instr
// d_src_addr_i    in   NUM_SRC*REG_AW decode source regs, src k at [k*REG_AW +: REG_AW]
// d_src_used_i    in   NUM_SRC        per-source "operand read" flags
// x_valid_i       in   1              execute stage holds valid instr
// x_is_load_i     in   1              execute instr is a load
// x_rd_we_i       in   1              execute instr writes rd
// x_rd_addr_i     in   REG_AW         execute destination reg
// x_multi_req_i   in   1              execute needs multi-cycle memory access
// x_multi_len_i   in   CNT_W          total stall cycles for that access
// cu_stall_si_i   in   1              control unit: self-instruct start
// x_release_f_i   in   1              execute: self-instruct done, release fetch
// br_taken_i      in   1              branch/jump resolved taken in execute
// stall_fetch_o   out  1              hold fetch
// stall_decode_o  out  1              hold F/D and D/X regs
// stall_pc_o      out  1              hold PC
// flush_decode_o  out  1              bubble into decode
// flush_execute_o out  1              bubble into execute
// busy_o          out  1              FSM not IDLE
// BEHAVIOUR
// - Reset: state IDLE, cnt 0, all outputs 0 while rst_i=1 (overrides all inputs).
// - Outputs combinational from state/cnt/inputs; state, cnt registered on clk_i.
// - States: IDLE, MULTI, SELF. Priority: br_taken_i > MULTI/multi req > load-use > SELF.
// - lu_hit = d_valid & x_valid & x_is_load & x_rd_we & !(R0_ZERO & rd==0)
//   & OR_k(d_src_used[k] & src[k]==rd). Checked only in IDLE with x_multi_req_i=0.
// - lu_hit: stall_decode_o=stall_pc_o=flush_execute_o=1 for exactly one cycle.
// - IDLE & x_multi_req_i & len>=1: stall_decode_o=stall_pc_o=1 this cycle; len==1 stay
//   IDLE, else cnt<=len-1, go MULTI. len==0: request ignored, no stall.
// - MULTI: stall_decode_o=stall_pc_o=1; cnt<=cnt-1; cnt==1 -> IDLE next. x_multi_req_i
//   ignored in MULTI. Total stall = len cycles exactly; no load-use bubble after.
// - IDLE & cu_stall_si_i: stall_fetch_o=1, go SELF. SELF: stall_fetch_o=1 until
//   x_release_f_i; release cycle stall_fetch_o=0, IDLE next. release & si same cycle in
//   SELF: release wins. Multi req in SELF: serviced (stalls) while fetch stays held;
//   SELF resumes after count.
// - br_taken_i: flush_decode_o=flush_execute_o=1, all stalls 0, next state IDLE, cnt 0.
// - Mid-operation reset: same as power-on reset, next cycle IDLE.
// - busy_o = (state!=IDLE).
// CONFIGURATION
// HDU_PERF_EN defined: adds ports stall_cyc_o [31:0] (cycles with stall_decode_o=1) and
//   flush_cnt_o [15:0] (cycles with br_taken_i=1); both saturate at max, cleared by rst_i.
// HDU_PERF_EN undefined: ports and counters absent; all other behaviour identical.
// TESTING
// - rst_i=1 3 cycles with all inputs 1 -> all outputs 0; after release busy_o=0.
// - load x_rd=5, d_src0=5 used -> 1-cycle stall_decode/pc + flush_execute; rd=0 -> none.
// - x_multi_req_i=1,len=4 -> stall_decode/pc high exactly 4 cycles, busy_o 3 cycles.
// - cu_stall_si_i pulse, x_release_f_i 6 cycles later -> stall_fetch_o high 6 cycles.
// - br_taken_i in MULTI cnt=2 -> flush_decode/execute=1, stalls 0, IDLE next cycle.
// - HDU_PERF_EN: len=3 multi + 1 load-use -> stall_cyc_o=4; 2 branches -> flush_cnt_o=2.

Source files
------------

// File: rtl/hdu_ctrl.sv
// hdu_ctrl: hazard detection / stall controller for the in-order core.
// Detects load-use RAW hazards, counts out multi-cycle memory stalls, holds
// fetch during self-instruct sequences and flushes decode/execute on taken
// branches. Optional performance counters are enabled by defining HDU_PERF_EN.
// All outputs are driven only from state, counter and current inputs.
// There is no handshake; every input is a level that is sampled each cycle.
module hdu_ctrl #(
  parameter int REG_AW  = 4,
  parameter int NUM_SRC = 2,
  parameter int CNT_W   = 4,
  parameter bit R0_ZERO = 1'b1
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic                      d_valid_i,
  input  logic [NUM_SRC*REG_AW-1:0] d_src_addr_i,
  input  logic [NUM_SRC-1:0]        d_src_used_i,
  input  logic                      x_valid_i,
  input  logic                      x_is_load_i,
  input  logic                      x_rd_we_i,
  input  logic [REG_AW-1:0]         x_rd_addr_i,
  input  logic                      x_multi_req_i,
  input  logic [CNT_W-1:0]          x_multi_len_i,
  input  logic                      cu_stall_si_i,
  input  logic                      x_release_f_i,
  input  logic                      br_taken_i,
  output logic                      stall_fetch_o,
  output logic                      stall_decode_o,
  output logic                      stall_pc_o,
  output logic                      flush_decode_o,
  output logic                      flush_execute_o,
  output logic                      busy_o
`ifdef HDU_PERF_EN
  ,
  output logic [31:0]               stall_cyc_o,
  output logic [15:0]               flush_cnt_o
`endif
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_MULTI = 2'd1,
    ST_SELF  = 2'd2
  } state_e;

  localparam logic [CNT_W-1:0] CNT_ONE = 1;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  // Set while a multi-cycle access interrupted a self-instruct sequence;
  // the FSM returns to SELF (fetch still held) when the count runs out.
  logic             self_pend_q, self_pend_d;

  logic             src_hit;
  logic             lu_hit;
  logic             multi_ok;
  logic [CNT_W-1:0] len_m1;

  assign multi_ok = x_multi_req_i && (x_multi_len_i != '0);
  assign len_m1   = x_multi_len_i - CNT_ONE;

  // Any used decode source matching the execute destination register.
  always_comb begin
    src_hit = 1'b0;
    for (int k = 0; k < NUM_SRC; k++) begin
      if (d_src_used_i[k] && (d_src_addr_i[k*REG_AW +: REG_AW] == x_rd_addr_i)) begin
        src_hit = 1'b1;
      end
    end
  end

  assign lu_hit = d_valid_i && x_valid_i && x_is_load_i && x_rd_we_i &&
                  !(R0_ZERO && (x_rd_addr_i == '0)) && src_hit;

  // Next-state and output decode; branch beats everything except reset.
  always_comb begin
    state_d         = state_q;
    cnt_d           = cnt_q;
    self_pend_d     = self_pend_q;
    stall_fetch_o   = 1'b0;
    stall_decode_o  = 1'b0;
    stall_pc_o      = 1'b0;
    flush_decode_o  = 1'b0;
    flush_execute_o = 1'b0;
    busy_o          = 1'b0;
    if (rst_i) begin
      state_d     = ST_IDLE;
      cnt_d       = '0;
      self_pend_d = 1'b0;
    end else if (br_taken_i) begin
      busy_o          = (state_q != ST_IDLE);
      flush_decode_o  = 1'b1;
      flush_execute_o = 1'b1;
      state_d         = ST_IDLE;
      cnt_d           = '0;
      self_pend_d     = 1'b0;
    end else begin
      busy_o = (state_q != ST_IDLE);
      case (state_q)
        ST_IDLE: begin
          if (multi_ok) begin
            stall_decode_o = 1'b1;
            stall_pc_o     = 1'b1;
            if (x_multi_len_i != CNT_ONE) begin
              cnt_d       = len_m1;
              self_pend_d = 1'b0;
              state_d     = ST_MULTI;
            end
          end else if (!x_multi_req_i && lu_hit) begin
            stall_decode_o  = 1'b1;
            stall_pc_o      = 1'b1;
            flush_execute_o = 1'b1;
          end else if (cu_stall_si_i) begin
            stall_fetch_o = 1'b1;
            state_d       = ST_SELF;
          end
        end
        ST_MULTI: begin
          stall_decode_o = 1'b1;
          stall_pc_o     = 1'b1;
          stall_fetch_o  = self_pend_q && !x_release_f_i;
          if (x_release_f_i) begin
            self_pend_d = 1'b0;
          end
          cnt_d = cnt_q - CNT_ONE;
          if (cnt_q == CNT_ONE) begin
            state_d = (self_pend_q && !x_release_f_i) ? ST_SELF : ST_IDLE;
            cnt_d   = '0;
          end
        end
        ST_SELF: begin
          stall_fetch_o = !x_release_f_i;
          if (multi_ok) begin
            stall_decode_o = 1'b1;
            stall_pc_o     = 1'b1;
            if (x_multi_len_i != CNT_ONE) begin
              cnt_d       = len_m1;
              self_pend_d = !x_release_f_i;
              state_d     = ST_MULTI;
            end else if (x_release_f_i) begin
              state_d = ST_IDLE;
            end
          end else if (x_release_f_i) begin
            state_d = ST_IDLE;
          end
        end
        default: begin
          state_d     = ST_IDLE;
          cnt_d       = '0;
          self_pend_d = 1'b0;
        end
      endcase
    end
  end

  // State, stall counter and pending-self flag registers.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      self_pend_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      self_pend_q <= self_pend_d;
    end
  end

`ifdef HDU_PERF_EN
  logic [31:0] stall_cyc_q;
  logic [15:0] flush_cnt_q;

  // Saturating counts of decode-stall cycles and taken-branch cycles.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      stall_cyc_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      if (stall_decode_o && (stall_cyc_q != '1)) stall_cyc_q <= stall_cyc_q + 32'd1;
      if (br_taken_i && (flush_cnt_q != '1))     flush_cnt_q <= flush_cnt_q + 16'd1;
    end
  end

  assign stall_cyc_o = stall_cyc_q;
  assign flush_cnt_o = flush_cnt_q;
`endif

endmodule

// File: tb/tb_hdu_ctrl.sv
// Directed bench for hdu_ctrl. Output vector order used in checks:
// {stall_fetch, stall_decode, stall_pc, flush_decode, flush_execute, busy}.
module tb_hdu_ctrl;
  localparam int REG_AW  = 4;
  localparam int NUM_SRC = 2;
  localparam int CNT_W   = 4;

  logic                      clk;
  logic                      rst;
  logic                      d_valid;
  logic [NUM_SRC*REG_AW-1:0] d_src_addr;
  logic [NUM_SRC-1:0]        d_src_used;
  logic                      x_valid;
  logic                      x_is_load;
  logic                      x_rd_we;
  logic [REG_AW-1:0]         x_rd_addr;
  logic                      x_multi_req;
  logic [CNT_W-1:0]          x_multi_len;
  logic                      cu_stall_si;
  logic                      x_release_f;
  logic                      br_taken;
  logic                      stall_fetch, stall_decode, stall_pc;
  logic                      flush_decode, flush_execute, busy;
`ifdef HDU_PERF_EN
  logic [31:0]               stall_cyc;
  logic [15:0]               flush_cnt;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  hdu_ctrl #(.REG_AW(REG_AW), .NUM_SRC(NUM_SRC), .CNT_W(CNT_W), .R0_ZERO(1'b1)) dut (
    .clk_i           (clk),
    .rst_i           (rst),
    .d_valid_i       (d_valid),
    .d_src_addr_i    (d_src_addr),
    .d_src_used_i    (d_src_used),
    .x_valid_i       (x_valid),
    .x_is_load_i     (x_is_load),
    .x_rd_we_i       (x_rd_we),
    .x_rd_addr_i     (x_rd_addr),
    .x_multi_req_i   (x_multi_req),
    .x_multi_len_i   (x_multi_len),
    .cu_stall_si_i   (cu_stall_si),
    .x_release_f_i   (x_release_f),
    .br_taken_i      (br_taken),
    .stall_fetch_o   (stall_fetch),
    .stall_decode_o  (stall_decode),
    .stall_pc_o      (stall_pc),
    .flush_decode_o  (flush_decode),
    .flush_execute_o (flush_execute),
    .busy_o          (busy)
`ifdef HDU_PERF_EN
    ,
    .stall_cyc_o     (stall_cyc),
    .flush_cnt_o     (flush_cnt)
`endif
  );

  // Clock and reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Driver tasks
  task automatic tick();
    @(negedge clk);
  endtask

  task automatic clr_inputs();
    d_valid     = 1'b0;
    d_src_addr  = '0;
    d_src_used  = '0;
    x_valid     = 1'b0;
    x_is_load   = 1'b0;
    x_rd_we     = 1'b0;
    x_rd_addr   = '0;
    x_multi_req = 1'b0;
    x_multi_len = '0;
    cu_stall_si = 1'b0;
    x_release_f = 1'b0;
    br_taken    = 1'b0;
  endtask

  task automatic set_lu(input logic [3:0] rd, input logic [3:0] s0, input logic [3:0] s1,
                        input logic [1:0] used, input logic is_load);
    d_valid    = 1'b1;
    x_valid    = 1'b1;
    x_rd_we    = 1'b1;
    x_is_load  = is_load;
    x_rd_addr  = rd;
    d_src_addr = {s1, s0};
    d_src_used = used;
  endtask

  task automatic set_multi(input logic req, input logic [3:0] len);
    x_multi_req = req;
    x_multi_len = len;
  endtask

  // Scoreboard check
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [5:0] outs();
    return {stall_fetch, stall_decode, stall_pc, flush_decode, flush_execute, busy};
  endfunction

  // Check the combinational outputs for the current inputs, then advance a cycle.
  task automatic cyc(input string tag, input logic [5:0] exp);
    #1;
    chk(tag, {26'd0, outs()}, {26'd0, exp});
    tick();
  endtask

  task automatic do_reset();
    clr_inputs();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  initial begin
    // Reset with every input forced high
    rst = 1'b1;
    d_valid = 1'b1; d_src_addr = '1; d_src_used = '1; x_valid = 1'b1;
    x_is_load = 1'b1; x_rd_we = 1'b1; x_rd_addr = '1; x_multi_req = 1'b1;
    x_multi_len = '1; cu_stall_si = 1'b1; x_release_f = 1'b1; br_taken = 1'b1;
    tick();
    cyc("rst_c0", 6'b000000);
    cyc("rst_c1", 6'b000000);
    cyc("rst_c2", 6'b000000);
    rst = 1'b0;
    clr_inputs();
    cyc("post_rst_idle", 6'b000000);

    // Load-use hazards
    set_lu(4'd5, 4'd5, 4'd2, 2'b01, 1'b1);
    cyc("lu_src0", 6'b011010);
    clr_inputs();
    cyc("lu_after", 6'b000000);
    set_lu(4'd7, 4'd1, 4'd7, 2'b10, 1'b1);
    cyc("lu_src1", 6'b011010);
    set_lu(4'd7, 4'd7, 4'd7, 2'b00, 1'b1);
    cyc("lu_unused", 6'b000000);
    set_lu(4'd0, 4'd0, 4'd0, 2'b11, 1'b1);
    cyc("lu_r0", 6'b000000);
    set_lu(4'd5, 4'd5, 4'd5, 2'b11, 1'b0);
    cyc("lu_not_load", 6'b000000);
    clr_inputs();

    // Multi-cycle stall, len=4, with a load-use pattern present during MULTI
    set_multi(1'b1, 4'd4);
    cyc("multi4_c0", 6'b011000);
    set_multi(1'b0, 4'd0);
    set_lu(4'd5, 4'd5, 4'd2, 2'b01, 1'b1);
    cyc("multi4_c1", 6'b011001);
    clr_inputs();
    cyc("multi4_c2", 6'b011001);
    cyc("multi4_c3", 6'b011001);
    cyc("multi4_done", 6'b000000);

    // Boundary lengths
    set_multi(1'b1, 4'd0);
    cyc("multi_len0", 6'b000000);
    set_multi(1'b1, 4'd1);
    cyc("multi_len1", 6'b011000);
    clr_inputs();
    cyc("multi_len1_after", 6'b000000);

    // Self-instruct: pulse, release 6 cycles later
    cu_stall_si = 1'b1;
    cyc("self_c0", 6'b100000);
    cu_stall_si = 1'b0;
    for (int i = 1; i < 6; i++) cyc($sformatf("self_c%0d", i), 6'b100001);
    x_release_f = 1'b1;
    cyc("self_release", 6'b000001);
    x_release_f = 1'b0;
    cyc("self_idle", 6'b000000);

    // Release and self-instruct together while in SELF: release wins
    cu_stall_si = 1'b1;
    cyc("self2_enter", 6'b100000);
    x_release_f = 1'b1;
    cyc("self2_rel_si", 6'b000001);
    clr_inputs();
    cyc("self2_idle", 6'b000000);

    // Multi request while in SELF: fetch stays held, SELF resumes
    cu_stall_si = 1'b1;
    cyc("selfm_enter", 6'b100000);
    cu_stall_si = 1'b0;
    set_multi(1'b1, 4'd2);
    cyc("selfm_req", 6'b111001);
    set_multi(1'b0, 4'd0);
    cyc("selfm_multi", 6'b111001);
    cyc("selfm_back", 6'b100001);
    x_release_f = 1'b1;
    cyc("selfm_release", 6'b000001);
    x_release_f = 1'b0;
    cyc("selfm_idle", 6'b000000);

    // Branch while MULTI with cnt=2
    set_multi(1'b1, 4'd4);
    cyc("br_m_c0", 6'b011000);
    set_multi(1'b0, 4'd0);
    cyc("br_m_c1", 6'b011001);
    br_taken = 1'b1;
    cyc("br_m_flush", 6'b000111);
    br_taken = 1'b0;
    cyc("br_m_idle", 6'b000000);

    // Mid-operation reset
    set_multi(1'b1, 4'd5);
    cyc("mrst_c0", 6'b011000);
    set_multi(1'b0, 4'd0);
    rst = 1'b1;
    cyc("mrst_assert", 6'b000000);
    rst = 1'b0;
    cyc("mrst_idle", 6'b000000);

`ifdef HDU_PERF_EN
    do_reset();
    #1;
    chk("perf_rst_stall", stall_cyc, 32'd0);
    chk("perf_rst_flush", {16'd0, flush_cnt}, 32'd0);
    set_multi(1'b1, 4'd3);
    tick();
    set_multi(1'b0, 4'd0);
    tick();
    tick();
    set_lu(4'd5, 4'd5, 4'd2, 2'b01, 1'b1);
    tick();
    clr_inputs();
    br_taken = 1'b1;
    tick();
    br_taken = 1'b0;
    tick();
    br_taken = 1'b1;
    tick();
    br_taken = 1'b0;
    #1;
    chk("perf_stall_cyc", stall_cyc, 32'd4);
    chk("perf_flush_cnt", {16'd0, flush_cnt}, 32'd2);
`else
    do_reset();
`endif

    // Final report
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
